// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Brief    : 640x480@60 raster timing generator (positions, syncs, active,
//            line/frame ticks). Optional macro VGA_SYNC_ALIGN_EN delays
//            o_HSync/o_VSync/o_Active by one register stage.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  output logic [9:0] h_position,
  output logic [9:0] v_position,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic       o_Line_Tick,
  output logic       o_Frame_Tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] c_h_last     = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_v_last     = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_h_act      = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_act      = 10'(V_ACTIVE);
  localparam logic [9:0] c_hs_first   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_last    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_vs_first   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_last    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_cfg
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_wrap;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       line_tick_q, line_tick_d;
  logic       frame_tick_q, frame_tick_d;

  always_comb begin
    h_wrap = (h_q == c_h_last);
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == c_v_last) ? 10'd0 : v_q + 10'd1;
    end
  end

  // Decode the coordinates about to be registered so every output lines up
  // with h_position/v_position while still coming straight from a flop.
  always_comb begin
    active_d     = (h_d < c_h_act) && (v_d < c_v_act);
    hsync_d      = !((h_d >= c_hs_first) && (h_d <= c_hs_last));
    vsync_d      = !((v_d >= c_vs_first) && (v_d <= c_vs_last));
    line_tick_d  = (h_d == c_h_act);
    frame_tick_d = (h_d == 10'd0) && (v_d == c_v_act);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      h_q          <= 10'd0;
      v_q          <= 10'd0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      active_q     <= 1'b1;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      active_q     <= active_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign h_position   = h_q;
  assign v_position   = v_q;
  assign o_Line_Tick  = line_tick_q;
  assign o_Frame_Tick = frame_tick_q;

`ifdef VGA_SYNC_ALIGN_EN
  // Extra stage matches sprite colour outputs registered one cycle later.
  logic hsync_dly_q, hsync_dly_d;
  logic vsync_dly_q, vsync_dly_d;
  logic active_dly_q, active_dly_d;

  always_comb begin
    hsync_dly_d  = hsync_q;
    vsync_dly_d  = vsync_q;
    active_dly_d = active_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hsync_dly_q  <= 1'b1;
      vsync_dly_q  <= 1'b1;
      active_dly_q <= 1'b1;
    end else begin
      hsync_dly_q  <= hsync_dly_d;
      vsync_dly_q  <= vsync_dly_d;
      active_dly_q <= active_dly_d;
    end
  end

  assign o_HSync  = hsync_dly_q;
  assign o_VSync  = vsync_dly_q;
  assign o_Active = active_dly_q;
`else
  assign o_HSync  = hsync_q;
  assign o_VSync  = vsync_q;
  assign o_Active = active_q;
`endif

endmodule
`default_nettype wire
